load_store_unit: RTL and testbench

//  Memory-side responder to the decoder's mem_rd_en/mem_wr_en/mem_byte_en/mem_signed controls.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/mem_data_aligner.sv | 36 +++
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 tb/tb_load_store_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    Idle,
    Wait,
    Done
  } lsu_state_t;

  function automatic logic [3:0] access_size(input logic [7:0] be);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n += 4'(be[i]);
    return n;
  endfunction

  // Sizes are powers of two, so offset % size is a low-bit mask.
  function automatic logic is_misaligned(
    input logic [2:0] off,
    input logic [3:0] size
  );
    if (size == 4'd0) return 1'b0;
    return (off & (size[2:0] - 3'd1)) != 3'd0;
  endfunction

endpackage

// File: rtl/mem_data_aligner.sv
// Lane alignment for stores and extraction/extension for loads.
module mem_data_aligner #(
  parameter int DATA_SIZE = 64,
  parameter int BYTE_NUM  = DATA_SIZE / 8
) (
  input  logic [$clog2(BYTE_NUM)-1:0] offset,
  input  logic [BYTE_NUM-1:0]         byte_en,
  input  logic                        signed_ld,
  input  logic [DATA_SIZE-1:0]        wr_data,
  input  logic [DATA_SIZE-1:0]        bus_rd_data,
  output logic [DATA_SIZE-1:0]        bus_wr_data,
  output logic [BYTE_NUM-1:0]         bus_byte_en,
  output logic [DATA_SIZE-1:0]        ld_data
);

  logic [DATA_SIZE-1:0] sh;
  logic [DATA_SIZE-1:0] mask;
  logic                 sign;

  assign bus_wr_data = wr_data << {offset, 3'b000};
  assign bus_byte_en = byte_en << offset;
  assign sh          = bus_rd_data >> {offset, 3'b000};

  // The highest enabled lane carries the sign bit.
  always_comb begin
    mask = '0;
    sign = 1'b0;
    for (int i = 0; i < BYTE_NUM; i++) begin
      mask[8*i +: 8] = {8{byte_en[i]}};
      if (byte_en[i]) sign = sh[8*i+7];
    end
    ld_data = (sh & mask)
            | ((signed_ld && sign) ? ~mask : '0);
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: bus handshake, alignment, stall.
// Optional ack timeout enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_SIZE = 64,
  parameter int BYTE_NUM  = DATA_SIZE / 8
`ifdef LSU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [BYTE_NUM-1:0]  byte_en,
  input  logic                 signed_ld,
  input  logic [DATA_SIZE-1:0] addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 done,
  output logic                 stall,
  output logic                 load_misaligned,
  output logic                 store_misaligned,
  output logic                 access_fault,
  output logic [DATA_SIZE-1:0] bus_addr,
  output logic [DATA_SIZE-1:0] bus_wr_data,
  output logic [BYTE_NUM-1:0]  bus_byte_en,
  output logic                 bus_rd_en,
  output logic                 bus_wr_en,
  input  logic                 bus_ack,
  input  logic [DATA_SIZE-1:0] bus_rd_data
);

  localparam int OFF_W = $clog2(BYTE_NUM);

  lsu_state_t state_q, state_d;

  logic [DATA_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0] wdata_q;
  logic [BYTE_NUM-1:0]  ben_q;
  logic                 sgn_q;
  logic                 store_q;

  logic                 mis;
  logic                 accept;
  logic                 in_wait;
  logic                 timeout;
  logic [DATA_SIZE-1:0] al_wdata;
  logic [BYTE_NUM-1:0]  al_ben;
  logic [DATA_SIZE-1:0] ld_data;

  assign mis = is_misaligned(3'(addr[OFF_W-1:0]),
                             access_size(8'(byte_en)));
  assign in_wait = (state_q == Wait);

  mem_data_aligner #(
    .DATA_SIZE (DATA_SIZE),
    .BYTE_NUM  (BYTE_NUM)
  ) u_align (
    .offset      (addr_q[OFF_W-1:0]),
    .byte_en     (ben_q),
    .signed_ld   (sgn_q),
    .wr_data     (wdata_q),
    .bus_rd_data (bus_rd_data),
    .bus_wr_data (al_wdata),
    .bus_byte_en (al_ben),
    .ld_data     (ld_data)
  );

  assign bus_addr    = in_wait
                     ? addr_q & ~DATA_SIZE'(BYTE_NUM - 1)
                     : '0;
  assign bus_wr_data = in_wait ? al_wdata : '0;
  assign bus_byte_en = in_wait ? al_ben : '0;

  always_comb begin
    state_d          = state_q;
    accept           = 1'b0;
    stall            = 1'b0;
    done             = 1'b0;
    load_misaligned  = 1'b0;
    store_misaligned = 1'b0;
    bus_rd_en        = 1'b0;
    bus_wr_en        = 1'b0;
    unique case (state_q)
      Idle: begin
        if (rd_en || wr_en) begin
          if (mis) begin
            store_misaligned = wr_en;
            load_misaligned  = !wr_en;
          end else begin
            accept  = 1'b1;
            stall   = 1'b1;
            state_d = Wait;
          end
        end
      end
      Wait: begin
        stall     = 1'b1;
        bus_rd_en = !store_q;
        bus_wr_en = store_q;
        if (bus_ack || timeout) state_d = Done;
      end
      Done: begin
        done    = 1'b1;
        state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= Idle;
      addr_q  <= '0;
      wdata_q <= '0;
      ben_q   <= '0;
      sgn_q   <= 1'b0;
      store_q <= 1'b0;
      rd_data <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wr_data;
        ben_q   <= byte_en;
        sgn_q   <= signed_ld;
        store_q <= wr_en;
      end
      if (in_wait && bus_ack)
        rd_data <= store_q ? '0 : ld_data;
      else if (timeout)
        rd_data <= '0;
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8)
                       ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             fault_q;

  // cnt_q counts completed Wait cycles; the last one times out.
  assign timeout = in_wait && !bus_ack
                && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign access_fault = (state_q == Done) && fault_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else if (in_wait) begin
      cnt_q <= cnt_q + 1'b1;
      if (timeout) fault_q <= 1'b1;
    end
  end
`else
  assign timeout      = 1'b0;
  assign access_fault = 1'b0;
`endif

  a_rd_wr_excl: assert property (
    @(posedge clock) disable iff (!reset_n)
    !(state_q == Idle && rd_en && wr_en)
  ) else $warning("rd_en and wr_en both set; load ignored");

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed vectors.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rd_en, wr_en, signed_ld;
  logic [7:0]  byte_en;
  logic [63:0] addr, wr_data;
  logic [63:0] rd_data;
  logic        done, stall;
  logic        load_misaligned, store_misaligned, access_fault;
  logic [63:0] bus_addr, bus_wr_data;
  logic [7:0]  bus_byte_en;
  logic        bus_rd_en, bus_wr_en, bus_ack;
  logic [63:0] bus_rd_data;

  int total = 0;
  int bad   = 0;

  int          n_stall;
  logic        got_done, got_fault, got_strobe;
  logic [63:0] cap_addr, cap_wd;
  logic [7:0]  cap_be;
  logic        cap_rd, cap_wr;

  always #5 clock = ~clock;

`ifdef LSU_TIMEOUT_EN
  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
`else
  load_store_unit dut (
`endif
    .clock            (clock),
    .reset_n          (reset_n),
    .rd_en            (rd_en),
    .wr_en            (wr_en),
    .byte_en          (byte_en),
    .signed_ld        (signed_ld),
    .addr             (addr),
    .wr_data          (wr_data),
    .rd_data          (rd_data),
    .done             (done),
    .stall            (stall),
    .load_misaligned  (load_misaligned),
    .store_misaligned (store_misaligned),
    .access_fault     (access_fault),
    .bus_addr         (bus_addr),
    .bus_wr_data      (bus_wr_data),
    .bus_byte_en      (bus_byte_en),
    .bus_rd_en        (bus_rd_en),
    .bus_wr_en        (bus_wr_en),
    .bus_ack          (bus_ack),
    .bus_rd_data      (bus_rd_data)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ack_at: Wait cycle (1-based) carrying bus_ack; 0 = never.
  task automatic access(input logic rd, input logic wr,
                        input logic [7:0] be, input logic sgn,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] rdat, input int ack_at);
    @(negedge clock);
    rd_en = rd; wr_en = wr; byte_en = be; signed_ld = sgn;
    addr = a; wr_data = wd; bus_rd_data = rdat;
    #1 n_stall = stall ? 1 : 0;
    @(negedge clock);
    rd_en = 1'b0; wr_en = 1'b0; byte_en = 8'h01;
    signed_ld = ~sgn; addr = '1; wr_data = '1;
    cap_addr = bus_addr; cap_wd = bus_wr_data;
    cap_be = bus_byte_en; cap_rd = bus_rd_en; cap_wr = bus_wr_en;
    got_done = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (stall) n_stall++;
      bus_ack = (c == ack_at);
      @(negedge clock);
      bus_ack = 1'b0;
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    got_fault  = access_fault;
    got_strobe = bus_rd_en | bus_wr_en;
  endtask

  initial begin
    reset_n = 1'b0;
    rd_en = 1'b0; wr_en = 1'b0; signed_ld = 1'b0;
    byte_en = '0; addr = '0; wr_data = '0;
    bus_ack = 1'b0; bus_rd_data = '1;
    repeat (3) @(negedge clock);
    check("rst_rd_data", rd_data, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall, 0);
    check("rst_lmis", load_misaligned, 0);
    check("rst_smis", store_misaligned, 0);
    check("rst_fault", access_fault, 0);
    check("rst_baddr", bus_addr, 0);
    check("rst_bwd", bus_wr_data, 0);
    check("rst_bbe", bus_byte_en, 0);
    check("rst_brd", bus_rd_en, 0);
    check("rst_bwr", bus_wr_en, 0);
    reset_n = 1'b1;

    access(0, 1, 8'hFF, 0, 64'h1000, 64'h1122334455667788, 0, 1);
    check("sd_stalls", n_stall, 2);
    check("sd_done", got_done, 1);
    check("sd_bwr", cap_wr, 1);
    check("sd_brd", cap_rd, 0);
    check("sd_be", cap_be, 8'hFF);
    check("sd_wd", cap_wd, 64'h1122334455667788);
    check("sd_addr", cap_addr, 64'h1000);
    check("sd_rd_data", rd_data, 0);
    check("sd_strobe_done", got_strobe, 0);
    @(negedge clock);
    check("sd_done_pulse", done, 0);

    access(1, 0, 8'h01, 1, 64'h1003, 0, 64'h1122334480667788, 1);
    check("lb_be", cap_be, 8'h08);
    check("lb_addr", cap_addr, 64'h1000);
    check("lb_brd", cap_rd, 1);
    check("lb_data", rd_data, 64'hFFFFFFFFFFFFFF80);
    access(1, 0, 8'h01, 0, 64'h1003, 0, 64'h1122334480667788, 1);
    check("lbu_data", rd_data, 64'h80);

    access(0, 1, 8'h03, 0, 64'h1006, 64'hBEEF, 0, 2);
    check("sh_be", cap_be, 8'hC0);
    check("sh_wd", cap_wd, 64'hBEEF000000000000);
    check("sh_rd_data", rd_data, 0);

    access(1, 0, 8'h03, 1, 64'h1006, 0, 64'h7ABC123456789ABC, 1);
    check("lh_pos", rd_data, 64'h7ABC);
    access(1, 0, 8'h0F, 1, 64'h1004, 0, 64'h87654321DEADBEEF, 1);
    check("lw_data", rd_data, 64'hFFFFFFFF87654321);
    access(1, 0, 8'h0F, 0, 64'h1004, 0, 64'h87654321DEADBEEF, 1);
    check("lwu_data", rd_data, 64'h0000000087654321);

    @(negedge clock);
    rd_en = 1'b1; byte_en = 8'h0F; addr = 64'h1002; signed_ld = 1'b0;
    #1;
    check("lw_mis_pulse", load_misaligned, 1);
    check("lw_mis_smis", store_misaligned, 0);
    check("lw_mis_stall", stall, 0);
    check("lw_mis_brd", bus_rd_en, 0);
    @(negedge clock);
    rd_en = 1'b0;
    #1;
    check("lw_mis_brd2", bus_rd_en, 0);
    check("lw_mis_end", load_misaligned, 0);
    check("lw_mis_hold", rd_data, 64'h0000000087654321);
    @(negedge clock);
    wr_en = 1'b1; byte_en = 8'hFF; addr = 64'h1004;
    #1;
    check("sd_mis_pulse", store_misaligned, 1);
    check("sd_mis_bwr", bus_wr_en, 0);
    @(negedge clock);
    wr_en = 1'b0;

    access(1, 0, 8'hFF, 0, 64'h2008, 0, 64'hCAFEF00D12345678, 5);
    check("ack5_stalls", n_stall, 6);
    check("ack5_done", got_done, 1);
    check("ack5_data", rd_data, 64'hCAFEF00D12345678);

`ifdef LSU_TIMEOUT_EN
    access(1, 0, 8'hFF, 0, 64'h3000, 0, 64'h5555, 0);
    check("to_stalls", n_stall, 5);
    check("to_done", got_done, 1);
    check("to_fault", got_fault, 1);
    check("to_data", rd_data, 0);
    check("to_strobe", got_strobe, 0);
`else
    access(1, 0, 8'hFF, 0, 64'h3000, 0, 64'h5555, 12);
    check("noto_stalls", n_stall, 13);
    check("noto_fault", got_fault, 0);
    check("noto_data", rd_data, 64'h5555);
`endif

    @(negedge clock);
    rd_en = 1'b1; byte_en = 8'hFF; addr = 64'h4000; signed_ld = 1'b0;
    @(negedge clock);
    rd_en = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_mid_brd", bus_rd_en, 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_brd0", bus_rd_en, 0);
    check("rst_mid_stall", stall, 0);
    check("rst_mid_data", rd_data, 0);
    @(negedge clock);
    reset_n = 1'b1;
    bus_ack = 1'b1;
    @(negedge clock);
    bus_ack = 1'b0;
    check("rst_mid_nodone", done, 0);
    @(negedge clock);
    check("rst_mid_nodone2", done, 0);
    check("rst_mid_idle", stall, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
